// File: rtl/fdct4_pkg.sv
// Shared widths, DCT coefficients and FSM states for the 4-point forward DCT row block.
package fdct4_pkg;
    localparam int DATA_W = 25;
    localparam int INT_W  = 36;

    localparam int C64 = 64;
    localparam int C83 = 83;
    localparam int C36 = 36;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [INT_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        FILL,
        CALC,
        SEND
    } state_t;
endpackage

// File: rtl/fdct4_if.sv
// Sample-in / coefficient-out stream bundle of the row DCT; slave is the DCT side.
interface fdct4_if;
    import fdct4_pkg::*;

    data_t      d_in;
    logic       in_valid;
    logic       in_ready;
    data_t      d_out;
    logic [1:0] out_idx;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output d_in, in_valid, out_ready,
        input  in_ready, d_out, out_idx, out_valid
    );

    modport slave (
        input  d_in, in_valid, out_ready,
        output in_ready, d_out, out_idx, out_valid
    );
endinterface

// File: rtl/fdct4_butterfly.sv
// Combinational even/odd butterfly and coefficient multiply of the 4-point DCT.
module fdct4_butterfly
    import fdct4_pkg::*;
(
    input  data_t x0,
    input  data_t x1,
    input  data_t x2,
    input  data_t x3,
    output acc_t  y0,
    output acc_t  y1,
    output acc_t  y2,
    output acc_t  y3
);
    localparam acc_t K64 = acc_t'(C64);
    localparam acc_t K83 = acc_t'(C83);
    localparam acc_t K36 = acc_t'(C36);

    acc_t e0, e1, o0, o1;

    // Widen before adding so sums of full-scale samples cannot wrap.
    assign e0 = acc_t'(x0) + acc_t'(x3);
    assign e1 = acc_t'(x1) + acc_t'(x2);
    assign o0 = acc_t'(x0) - acc_t'(x3);
    assign o1 = acc_t'(x1) - acc_t'(x2);

    assign y0 = K64 * e0 + K64 * e1;
    assign y2 = K64 * e0 - K64 * e1;
    assign y1 = K83 * o0 + K36 * o1;
    assign y3 = K36 * o0 - K83 * o1;
endmodule

// File: rtl/fdct4_row.sv
// 4-point forward DCT over one row: collect 4 samples, compute, stream 4 rounded coefficients.
// Define FDCT4_SAT_EN to saturate results to 25 bits; otherwise they wrap.
module fdct4_row
    import fdct4_pkg::*;
#(
    parameter int SHIFT = 8,
    parameter int ADD   = 1 << (SHIFT - 1)
) (
    input logic    clk,
    input logic    reset,
    fdct4_if.slave bus
);
    localparam acc_t ADD_W = acc_t'(ADD);
`ifdef FDCT4_SAT_EN
    localparam acc_t SAT_MAX = acc_t'((1 << (DATA_W - 1)) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(1 << (DATA_W - 1)));
`endif

    state_t     state, state_next;
    logic [1:0] cnt;
    logic [1:0] out_idx;
    data_t      samples [4];
    data_t      results [4];
    acc_t       y [4];
    logic       in_fire, out_fire;

    function automatic data_t narrow(input acc_t v);
        acc_t s;
        s = (v + ADD_W) >>> SHIFT;
`ifdef FDCT4_SAT_EN
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end
`endif
        return data_t'(s);
    endfunction

    fdct4_butterfly u_butterfly (
        .x0(samples[0]),
        .x1(samples[1]),
        .x2(samples[2]),
        .x3(samples[3]),
        .y0(y[0]),
        .y1(y[1]),
        .y2(y[2]),
        .y3(y[3])
    );

    assign in_fire  = (state == FILL) && bus.in_valid;
    assign out_fire = (state == SEND) && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            FILL: begin
                bus.in_ready = 1'b1;
                if (in_fire && cnt == 2'd3) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = SEND;
            end
            SEND: begin
                bus.out_valid = 1'b1;
                if (out_fire && out_idx == 2'd3) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Both counters wrap naturally to 0 after index 3, ready for the next block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 2'd0;
            out_idx <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                samples[i] <= '0;
                results[i] <= '0;
            end
        end else begin
            if (in_fire) begin
                samples[cnt] <= bus.d_in;
                cnt          <= cnt + 2'd1;
            end
            if (state == CALC) begin
                for (int i = 0; i < 4; i++) begin
                    results[i] <= narrow(y[i]);
                end
                out_idx <= 2'd0;
            end
            if (out_fire) begin
                out_idx <= out_idx + 2'd1;
            end
        end
    end

    assign bus.out_idx = out_idx;
    assign bus.d_out   = results[out_idx];
endmodule

// File: tb/tb_fdct4_row.sv
// Self-checking bench for fdct4_row: behavioural DCT model, per-cycle handshake/latency compare,
// directed literal cases and randomized blocks under random backpressure.
module tb_fdct4_row;
    import fdct4_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fdct4_if bus ();
    fdct4_if bus1 ();

    fdct4_row #(.SHIFT(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    fdct4_row #(.SHIFT(1)) dut_s1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     x3cyc = 0;
    bit     busy = 1'b0;
    int     nsamp = 0;
    longint part [4];
    longint expq [$];
    int     ready_mode = 0;
    bit     ready_force = 1'b1;

`ifdef FDCT4_SAT_EN
    localparam longint EXP_S1_Y0 = 16777215;
`else
    localparam longint EXP_S1_Y0 = -128;
`endif

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic longint narrow_ref(input longint v);
`ifdef FDCT4_SAT_EN
        if (v > 16777215) return 16777215;
        if (v < -16777216) return -16777216;
        return v;
`else
        longint m;
        m = v % 33554432;
        if (m < 0) m = m + 33554432;
        if (m >= 16777216) m = m - 33554432;
        return m;
`endif
    endfunction

    function automatic longint model_coef(input longint x0, input longint x1, input longint x2,
                                          input longint x3, input int k, input int shift);
        longint e0, e1, o0, o1, yv;
        e0 = x0 + x3;
        e1 = x1 + x2;
        o0 = x0 - x3;
        o1 = x1 - x2;
        case (k)
            0:       yv = 64 * e0 + 64 * e1;
            1:       yv = 83 * o0 + 36 * o1;
            2:       yv = 64 * e0 - 64 * e1;
            default: yv = 36 * o0 - 83 * o1;
        endcase
        return narrow_ref((yv + (longint'(1) <<< (shift - 1))) >>> shift);
    endfunction

    function automatic longint rand_sample();
        if ($urandom_range(0, 1) == 1) return longint'(data_t'($urandom));
        return longint'($urandom_range(0, 2047)) - 1024;
    endfunction

    // Downstream ready: 0 = always ready, 1 = random, 2 = follows ready_force.
    initial begin
        bus.out_ready  = 1'b1;
        bus1.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = ready_force;
            endcase
        end
    end

    // Compare process: the model knows a block is busy from x3 acceptance until y3 leaves.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                checkOutput("reset_out_valid", bus.out_valid, 0);
                checkOutput("reset_d_out", bus.d_out, 0);
                checkOutput("reset_out_idx", bus.out_idx, 0);
                nsamp = 0;
                expq.delete();
                busy = 1'b0;
            end else begin
                checkOutput("in_ready", bus.in_ready, !busy);
                checkOutput("out_valid", bus.out_valid, busy && (cyc >= x3cyc + 2));
                if (bus.in_valid && bus.in_ready) begin
                    part[nsamp] = bus.d_in;
                    nsamp++;
                    if (nsamp == 4) begin
                        for (int k = 0; k < 4; k++) begin
                            expq.push_back(model_coef(part[0], part[1], part[2], part[3], k, 8));
                        end
                        nsamp = 0;
                        busy  = 1'b1;
                        x3cyc = cyc;
                    end
                end
                if (bus.out_valid) begin
                    if (expq.size() == 0) begin
                        checkOutput("spurious_out", bus.out_valid, 0);
                    end else begin
                        checkOutput("d_out", bus.d_out, expq[0]);
                        checkOutput("out_idx", bus.out_idx, 4 - expq.size());
                        if (bus.out_ready) begin
                            void'(expq.pop_front());
                            if (expq.size() == 0) busy = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input longint x0, input longint x1, input longint x2,
                                 input longint x3, input bit gaps);
        longint xs [4];
        int     waited;
        int     idle;
        xs[0] = x0;
        xs[1] = x1;
        xs[2] = x2;
        xs[3] = x3;
        for (int i = 0; i < 4; i++) begin
            idle = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < idle; g++) begin
                bus.in_valid = 1'b0;
                bus.d_in     = data_t'($urandom);
                @(posedge clk);
                #1;
            end
            bus.d_in     = data_t'(xs[i]);
            bus.in_valid = 1'b1;
            waited       = 0;
            @(negedge clk);
            while (!bus.in_ready && waited < 60) begin
                waited++;
                @(negedge clk);
            end
            if (!bus.in_ready) begin
                checkOutput("in_ready_timeout", bus.in_ready, 1);
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.d_in     = data_t'($urandom);
    endtask

    task automatic expectBlock(input longint e0, input longint e1, input longint e2,
                               input longint e3, input string tag);
        longint es [4];
        int     waited;
        es[0] = e0;
        es[1] = e1;
        es[2] = e2;
        es[3] = e3;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            @(negedge clk);
            while (!(bus.out_valid && bus.out_ready) && waited < 60) begin
                waited++;
                @(negedge clk);
            end
            if (!(bus.out_valid && bus.out_ready)) begin
                checkOutput({tag, "_timeout"}, bus.out_valid, 1);
                break;
            end
            checkOutput($sformatf("%s_y%0d", tag, k), bus.d_out, es[k]);
            checkOutput($sformatf("%s_idx%0d", tag, k), bus.out_idx, k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int waited = 0;
        @(negedge clk);
        while (busy && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (busy) checkOutput("drain_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t1;
        int waited;
        bus.d_in      = '0;
        bus.in_valid  = 1'b0;
        bus1.d_in     = '0;
        bus1.in_valid = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("pin_ones_y0", model_coef(1, 1, 1, 1, 0, 8), 1);
        checkOutput("pin_pos_y1", model_coef(256, 0, 0, 0, 1, 8), 83);
        checkOutput("pin_neg_y3", model_coef(-256, 0, 0, 0, 3, 8), -36);
        checkOutput("pin_s1_y0", model_coef(16777215, 16777215, 16777215, 16777215, 0, 1), EXP_S1_Y0);

        applyStimulus(1, 1, 1, 1, 1'b0);
        expectBlock(1, 0, 0, 0, "ones");
        applyStimulus(256, 0, 0, 0, 1'b1);
        expectBlock(64, 83, 64, 36, "pos256");
        applyStimulus(-256, 0, 0, 0, 1'b0);
        expectBlock(-64, -83, -64, -36, "neg256");

        applyStimulus(10, -20, 30, -40, 1'b0);
        t1 = x3cyc;
        applyStimulus(5, 6, 7, 8, 1'b0);
        checkOutput("block_period", x3cyc - t1, 9);
        waitIdle();

        // Hold out_ready low for three cycles while the second coefficient is on the bus.
        ready_force = 1'b1;
        ready_mode  = 2;
        applyStimulus(256, 0, 0, 0, 1'b0);
        waited = 0;
        @(negedge clk);
        while (!(bus.out_valid && bus.out_idx == 2'd0) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        checkOutput("bp_reach_y0", bus.out_valid, 1);
        ready_force = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_hold_d", bus.d_out, 83);
            checkOutput("bp_hold_idx", bus.out_idx, 1);
            checkOutput("bp_hold_valid", bus.out_valid, 1);
        end
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        waitIdle();
        ready_mode = 0;

        bus.d_in     = data_t'(7);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.d_in = data_t'(-3);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_valid", bus.out_valid, 0);
        checkOutput("post_reset_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(1, 1, 1, 1, 1'b0);
        expectBlock(1, 0, 0, 0, "after_reset");

        ready_mode = 1;
        for (int b = 0; b < 40; b++) begin
            applyStimulus(rand_sample(), rand_sample(), rand_sample(), rand_sample(), 1'b1);
        end
        waitIdle();
        ready_mode = 0;

        bus1.d_in     = data_t'(16777215);
        bus1.in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!bus1.out_valid && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        checkOutput("s1_y0", bus1.d_out, EXP_S1_Y0);
        checkOutput("s1_y0_model", bus1.d_out,
                    model_coef(16777215, 16777215, 16777215, 16777215, 0, 1));
        checkOutput("s1_idx", bus1.out_idx, 0);
        checkOutput("s1_valid", bus1.out_valid, 1);
        repeat (8) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: run still active, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fdct4_row.md
FDCT4_ROW -- requirements
Module: fdct4_row

Interface
REQ-001 Parameter SHIFT, default 8: output rounding right-shift amount; legal range 1..16.
REQ-002 Parameter ADD, default 1<<(SHIFT-1): rounding offset added before the shift.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 d_in  input  25  signed residual sample, presented in order x0, x1, x2, x3.
REQ-006 in_valid  input  1  d_in valid this cycle.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 d_out  output  25  signed DCT coefficient, emitted in order y0, y1, y2, y3.
REQ-009 out_idx  output  2  coefficient index of the current d_out.
REQ-010 out_valid  output  1  d_out and out_idx valid.
REQ-011 out_ready  input  1  downstream accepts d_out this cycle.

Function
REQ-012 Sample transfer SHALL occur on a clock edge where in_valid and in_ready are both 1; output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-013 FSM states SHALL be FILL, CALC and SEND; the reset state SHALL be FILL.
REQ-014 FILL: in_ready=1, out_valid=0; each transfer stores into slot cnt and increments the 2-bit cnt; the transfer at cnt=3 moves to CALC.
REQ-015 CALC (exactly 1 cycle): in_ready=0, out_valid=0; compute and register all four results; move to SEND with out_idx=0.
REQ-016 Butterfly: e0=x0+x3, e1=x1+x2, o0=x0-x3, o1=x1-x2.
REQ-017 Transform: y0=64*e0+64*e1, y2=64*e0-64*e1, y1=83*o0+36*o1, y3=36*o0-83*o1.
REQ-018 Internal arithmetic SHALL be signed, 36 bits wide, with no intermediate overflow.
REQ-019 Each output SHALL be (y+ADD)>>>SHIFT (arithmetic shift), then narrowed to 25 bits per REQ-029.
REQ-020 SEND: in_ready=0, out_valid=1; d_out and out_idx SHALL remain stable while out_ready=0.
REQ-021 Each output transfer in SEND SHALL increment out_idx; the transfer at out_idx=3 SHALL return the FSM to FILL, with in_ready=1 on the next cycle.
REQ-022 Latency: with out_ready held at 1, y0 SHALL be valid 2 cycles after x3 is accepted; a block SHALL occupy 9 cycles (4 FILL + 1 CALC + 4 SEND).
REQ-023 in_valid SHALL be ignored outside FILL; out_ready SHALL be ignored outside SEND.

Reset
REQ-024 While reset=1, state SHALL be FILL, cnt=0, out_idx=0, d_out=0, out_valid=0, and in_ready=1 once reset is deasserted.
REQ-025 Reset mid-block SHALL discard buffered samples and results; the next 4 accepted samples SHALL form a fresh block.
REQ-026 Sample and result registers SHALL reset to 0.

Configuration
REQ-027 Macro FDCT4_SAT_EN selects how results are narrowed to 25 bits.
REQ-028 With FDCT4_SAT_EN defined, the shifted result SHALL saturate to [-16777216, 16777215].
REQ-029 Without FDCT4_SAT_EN, the shifted result SHALL be truncated to its low 25 bits (two's-complement wrap).

Structure
REQ-030 Package fdct4_pkg SHALL hold the constants C64=64, C83=83, C36=36, the data width (25), the internal width (36), and the FSM state enum.
REQ-031 Sub-module fdct4_butterfly SHALL implement REQ-016/REQ-017 combinationally; fdct4_row SHALL own all sequential logic (FSM, sample buffer, result registers, rounding and narrowing).

Verification (SHIFT=8 unless stated)
REQ-032 Input x=1,1,1,1 -> outputs 1,0,0,0 with out_idx 0..3.
REQ-033 Input x=256,0,0,0 -> outputs 64,83,64,36; input x=-256,0,0,0 -> outputs -64,-83,-64,-36.
REQ-034 Backpressure: out_ready=0 for 3 cycles while out_idx=1 of the 256,0,0,0 block -> d_out holds 83 and out_idx holds 1; no word is lost or repeated.
REQ-035 Latency and throughput: back-to-back blocks with out_ready=1 -> y0 valid exactly 2 cycles after x3 is accepted; in_ready=1 on the cycle after y3 transfers; 9 cycles per block.
REQ-036 Reset after 2 samples are accepted -> out_valid=0 and in_ready=1 after reset release; the next block 1,1,1,1 -> outputs 1,0,0,0.
REQ-037 SHIFT=1, x=16777215 for all four samples -> y0 = 16777215 with FDCT4_SAT_EN defined; y0 = -128 without it.
